// File: rtl/regfile_pkg.sv
// Shared widths, the zero-register index and the write-request type
// used by the register-file write-port arbiter.
package regfile_pkg;

  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 5;
  localparam int ZERO_REG  = 0;

  typedef struct packed {
    logic [RF_ADDR_W-1:0] addr;
    logic [RF_DATA_W-1:0] data;
  } wr_req_t;

  typedef enum logic {
    PRI_REQ0 = 1'b0,
    PRI_REQ1 = 1'b1
  } prio_e;

endpackage

// File: rtl/rfarb_hold_slot.sv
// One-entry writeback holding register: accepts when empty, drops writes
// to the zero register, and empties on the edge it is granted.
module rfarb_hold_slot
  import regfile_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  input  logic              clear,
  output logic              ready,
  output logic              full,
  output logic [ADDR_W-1:0] held_addr,
  output logic [DATA_W-1:0] held_data
);

  logic              full_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] data_reg;

  // Clear and accept are mutually exclusive: clear only when full, accept only when empty.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full_reg <= 1'b0;
      addr_reg <= '0;
      data_reg <= '0;
    end else if (clear) begin
      full_reg <= 1'b0;
    end else if (valid && !full_reg && (addr != ADDR_W'(ZERO_REG))) begin
      full_reg <= 1'b1;
      addr_reg <= addr;
      data_reg <= data;
    end
  end

  assign ready     = !full_reg;
  assign full      = full_reg;
  assign held_addr = addr_reg;
  assign held_data = data_reg;

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Arbitrates ALU (req 0) and load (req 1) writebacks onto the single register
// file write port. Define RFARB_RR_EN for round-robin, else req 1 wins ties.
module regfile_wr_arbiter
  import regfile_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req0_valid,
  input  logic [ADDR_W-1:0] i_req0_addr,
  input  logic [DATA_W-1:0] i_req0_data,
  output logic              o_req0_ready,
  input  logic              i_req1_valid,
  input  logic [ADDR_W-1:0] i_req1_addr,
  input  logic [DATA_W-1:0] i_req1_data,
  output logic              o_req1_ready,
  output logic              o_we,
  output logic [ADDR_W-1:0] o_waddr,
  output logic [DATA_W-1:0] o_wdata,
  output logic              o_busy
);

  logic [1:0]        req_valid;
  logic [1:0]        ready;
  logic [1:0]        full;
  logic [1:0]        grant;
  logic [ADDR_W-1:0] req_addr  [2];
  logic [DATA_W-1:0] req_data  [2];
  logic [ADDR_W-1:0] held_addr [2];
  logic [DATA_W-1:0] held_data [2];

  logic              we_reg;
  logic [ADDR_W-1:0] waddr_reg;
  logic [DATA_W-1:0] wdata_reg;

  assign req_valid   = {i_req1_valid, i_req0_valid};
  assign req_addr[0] = i_req0_addr;
  assign req_addr[1] = i_req1_addr;
  assign req_data[0] = i_req0_data;
  assign req_data[1] = i_req1_data;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_slot
      rfarb_hold_slot #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
      ) u_slot (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .valid    (req_valid[gi]),
        .addr     (req_addr[gi]),
        .data     (req_data[gi]),
        .clear    (grant[gi]),
        .ready    (ready[gi]),
        .full     (full[gi]),
        .held_addr(held_addr[gi]),
        .held_data(held_data[gi])
      );
    end
  endgenerate

`ifdef RFARB_RR_EN
  prio_e ptr_reg;
  prio_e ptr_next;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      ptr_reg <= PRI_REQ0;
    end else begin
      ptr_reg <= ptr_next;
    end
  end

  // After any grant the pointer favours the requester that was not served.
  always_comb begin
    ptr_next = ptr_reg;
    if (grant[0]) begin
      ptr_next = PRI_REQ1;
    end else if (grant[1]) begin
      ptr_next = PRI_REQ0;
    end
  end

  always_comb begin
    grant = full;
    if (full == 2'b11) begin
      grant = (ptr_reg == PRI_REQ0) ? 2'b01 : 2'b10;
    end
  end
`else
  always_comb begin
    grant = full;
    if (full == 2'b11) begin
      grant = 2'b10;
    end
  end
`endif

  // Address/data keep their last value when nothing is granted.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      we_reg    <= 1'b0;
      waddr_reg <= '0;
      wdata_reg <= '0;
    end else begin
      we_reg <= |grant;
      if (grant[0]) begin
        waddr_reg <= held_addr[0];
        wdata_reg <= held_data[0];
      end else if (grant[1]) begin
        waddr_reg <= held_addr[1];
        wdata_reg <= held_data[1];
      end
    end
  end

  assign o_req0_ready = ready[0];
  assign o_req1_ready = ready[1];
  assign o_we         = we_reg;
  assign o_waddr      = waddr_reg;
  assign o_wdata      = wdata_reg;
  assign o_busy       = (|full) | we_reg;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Scoreboard bench for regfile_wr_arbiter; expected writes are queued in grant
// order as stimulus is applied. Ordering follows RFARB_RR_EN when defined.
module tb_regfile_wr_arbiter;
  import regfile_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          i_clk;
  logic          i_rst_n;
  logic          i_req0_valid;
  logic [AW-1:0] i_req0_addr;
  logic [DW-1:0] i_req0_data;
  logic          o_req0_ready;
  logic          i_req1_valid;
  logic [AW-1:0] i_req1_addr;
  logic [DW-1:0] i_req1_data;
  logic          o_req1_ready;
  logic          o_we;
  logic [AW-1:0] o_waddr;
  logic [DW-1:0] o_wdata;
  logic          o_busy;

  wr_req_t exp_q[$];
  int tests_run    = 0;
  int tests_failed = 0;

  regfile_wr_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_req0_valid(i_req0_valid),
    .i_req0_addr (i_req0_addr),
    .i_req0_data (i_req0_data),
    .o_req0_ready(o_req0_ready),
    .i_req1_valid(i_req1_valid),
    .i_req1_addr (i_req1_addr),
    .i_req1_data (i_req1_data),
    .o_req1_ready(o_req1_ready),
    .o_we        (o_we),
    .o_waddr     (o_waddr),
    .o_wdata     (o_wdata),
    .o_busy      (o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Advance past the next rising edge; outputs are read and inputs changed 1ns later.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic push_exp(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_req_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic apply_reset();
    i_rst_n      = 1'b0;
    i_req0_valid = 1'b0;
    i_req1_valid = 1'b0;
    tick();
    i_rst_n = 1'b1;
    exp_q.delete();
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    tick();
    tick();
    tests_run++;
    if ({o_we, o_waddr, o_wdata} !== {1'b0, {AW{1'b0}}, {DW{1'b0}}}) begin
      tests_failed++;
      $display("FAIL reset_outputs: we=%0b waddr=%0h wdata=%0h required 0/0/0", o_we, o_waddr, o_wdata);
    end
    i_rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      tests_run++;
      if ({o_we, o_req0_ready, o_req1_ready, o_busy} !== 4'b0110) begin
        tests_failed++;
        $display("FAIL reset_idle cyc%0d: we/r0/r1/busy=%b required 0110", c, {o_we, o_req0_ready, o_req1_ready, o_busy});
      end
    end
    $display("[TB] reset/idle done");
  endtask

  task automatic test_single();
    wr_req_t e;
    i_req0_valid = 1'b1;
    i_req0_addr  = 5'd3;
    i_req0_data  = 32'h0098_B7D5;
    push_exp(5'd3, 32'h0098_B7D5);
    tick();
    i_req0_valid = 1'b0;
    tests_run++;
    if ({o_req0_ready, o_we, o_busy} !== 3'b001) begin
      tests_failed++;
      $display("FAIL single_accept: r0/we/busy=%b required 001", {o_req0_ready, o_we, o_busy});
    end
    tick();
    tests_run++;
    if (o_we !== 1'b1 || exp_q.size() == 0) begin
      tests_failed++;
      $display("FAIL single_we: we=%0b required 1", o_we);
    end else begin
      e = exp_q.pop_front();
      if (o_waddr !== e.addr || o_wdata !== e.data) begin
        tests_failed++;
        $display("FAIL single_data: addr=%0d data=%h required addr=%0d data=%h", o_waddr, o_wdata, e.addr, e.data);
      end
    end
    tests_run++;
    if (o_req0_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_ready: r0=%0b required 1", o_req0_ready);
    end
    tick();
    tests_run++;
    if ({o_we, o_busy} !== 2'b00) begin
      tests_failed++;
      $display("FAIL single_done: we/busy=%b required 00", {o_we, o_busy});
    end
    $display("[TB] single write addr=3 done");
  endtask

  task automatic test_conflict();
    wr_req_t e;
    i_req0_valid = 1'b1;
    i_req0_addr  = 5'd11;
    i_req0_data  = 32'h0001_3456;
    i_req1_valid = 1'b1;
    i_req1_addr  = 5'd5;
    i_req1_data  = 32'h0099_0D72;
`ifdef RFARB_RR_EN
    push_exp(5'd11, 32'h0001_3456);
    push_exp(5'd5, 32'h0099_0D72);
`else
    push_exp(5'd5, 32'h0099_0D72);
    push_exp(5'd11, 32'h0001_3456);
`endif
    tick();
    i_req0_valid = 1'b0;
    i_req1_valid = 1'b0;
    tests_run++;
    if ({o_req0_ready, o_req1_ready, o_we} !== 3'b000) begin
      tests_failed++;
      $display("FAIL conflict_accept: r0/r1/we=%b required 000", {o_req0_ready, o_req1_ready, o_we});
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      tests_run++;
      if (o_we !== 1'b1 || exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL conflict_we%0d: we=%0b required 1", k, o_we);
      end else begin
        e = exp_q.pop_front();
        if (o_waddr !== e.addr || o_wdata !== e.data) begin
          tests_failed++;
          $display("FAIL conflict_order%0d: addr=%0d data=%h required addr=%0d data=%h", k, o_waddr, o_wdata, e.addr, e.data);
        end
      end
    end
    tick();
    tests_run++;
    if ({o_we, o_busy} !== 2'b00) begin
      tests_failed++;
      $display("FAIL conflict_done: we/busy=%b required 00", {o_we, o_busy});
    end
    $display("[TB] conflict done");
  endtask

  task automatic test_zero_reg();
    i_req1_valid = 1'b1;
    i_req1_addr  = 5'd0;
    i_req1_data  = 32'hFFFF_FFFF;
    for (int c = 0; c < 4; c++) begin
      tick();
      tests_run++;
      if ({o_we, o_req1_ready, o_busy} !== 3'b010) begin
        tests_failed++;
        $display("FAIL zero_reg cyc%0d: we/r1/busy=%b required 010", c, {o_we, o_req1_ready, o_busy});
      end
    end
    i_req1_valid = 1'b0;
    $display("[TB] zero register drop done");
  endtask

  task automatic test_sustained();
    wr_req_t e;
    int i0 = 0;
    int i1 = 0;
    int writes = 0;
    int run = 0;
    int max_run = 0;
    logic r0, r1;
    for (int k = 0; k < 10; k++) begin
`ifdef RFARB_RR_EN
      push_exp(AW'(1 + k), 32'hA000_0000 + k);
      push_exp(AW'(21 + k), 32'hB000_0000 + k);
`else
      push_exp(AW'(21 + k), 32'hB000_0000 + k);
      push_exp(AW'(1 + k), 32'hA000_0000 + k);
`endif
    end
    for (int cyc = 0; cyc < 40; cyc++) begin
      i_req0_valid = (i0 < 10);
      i_req0_addr  = AW'(1 + i0);
      i_req0_data  = 32'hA000_0000 + i0;
      i_req1_valid = (i1 < 10);
      i_req1_addr  = AW'(21 + i1);
      i_req1_data  = 32'hB000_0000 + i1;
      r0 = o_req0_ready;
      r1 = o_req1_ready;
      tick();
      if (i_req0_valid && r0) i0++;
      if (i_req1_valid && r1) i1++;
      if (o_we === 1'b1) begin
        writes++;
        run++;
        if (run > max_run) max_run = run;
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL sustained_extra: unexpected write addr=%0d data=%h", o_waddr, o_wdata);
        end else begin
          e = exp_q.pop_front();
          if (o_waddr !== e.addr || o_wdata !== e.data) begin
            tests_failed++;
            $display("FAIL sustained_w%0d: addr=%0d data=%h required addr=%0d data=%h", writes, o_waddr, o_wdata, e.addr, e.data);
          end
        end
      end else begin
        run = 0;
      end
    end
    i_req0_valid = 1'b0;
    i_req1_valid = 1'b0;
    tests_run++;
    if (writes != 20 || exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL sustained_count: writes=%0d left=%0d required 20/0", writes, exp_q.size());
    end
    tests_run++;
    if (max_run != 20) begin
      tests_failed++;
      $display("FAIL sustained_backtoback: longest we run=%0d required 20", max_run);
    end
    $display("[TB] sustained contention: %0d writes", writes);
  endtask

  task automatic test_reset_mid();
    i_req0_valid = 1'b1;
    i_req0_addr  = 5'd7;
    i_req0_data  = 32'h7777_0007;
    i_req1_valid = 1'b1;
    i_req1_addr  = 5'd9;
    i_req1_data  = 32'h9999_0009;
    tick();
    i_req0_valid = 1'b0;
    i_req1_valid = 1'b0;
    tests_run++;
    if ({o_req0_ready, o_req1_ready, o_busy} !== 3'b001) begin
      tests_failed++;
      $display("FAIL midreset_full: r0/r1/busy=%b required 001", {o_req0_ready, o_req1_ready, o_busy});
    end
    i_rst_n = 1'b0;
    tick();
    i_rst_n = 1'b1;
    tests_run++;
    if ({o_we, o_req0_ready, o_req1_ready, o_busy} !== 4'b0110) begin
      tests_failed++;
      $display("FAIL midreset_after: we/r0/r1/busy=%b required 0110", {o_we, o_req0_ready, o_req1_ready, o_busy});
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      tests_run++;
      if (o_we !== 1'b0) begin
        tests_failed++;
        $display("FAIL midreset_dropped cyc%0d: we=%0b addr=%0d required no write", c, o_we, o_waddr);
      end
    end
    $display("[TB] reset mid-operation done");
  endtask

  initial begin
    i_rst_n      = 1'b0;
    i_req0_valid = 1'b0;
    i_req0_addr  = '0;
    i_req0_data  = '0;
    i_req1_valid = 1'b0;
    i_req1_addr  = '0;
    i_req1_data  = '0;
    #1;
    test_reset();
    test_single();
    apply_reset();
    test_conflict();
    test_zero_reg();
    apply_reset();
    test_sustained();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
